// File: rtl/jtframe_z80_romfetch.sv
// Z80 ROM fetch bridge: serves CPU byte reads from a held 16-bit SDRAM word
// and fetches a new word over a req/ack/dok handshake on a miss.
//
// SDRAM handshake: sdram_req is a level held high only in REQ with
// sdram_addr stable; the controller answers with a one-cycle sdram_ack
// (request taken) and later a one-cycle sdram_dok (sdram_data valid).
// An ack and a dok in the same REQ cycle count as ack followed by dok.
// At most one transaction is ever outstanding.
//
// Build option: define JTFRAME_Z80_ROMCACHE_EN to keep the held word valid
// across cpu_cs gaps (one-word cache). Without it the word is invalidated
// whenever cpu_cs is low, so each CPU access costs one SDRAM read.
module jtframe_z80_romfetch #(
  parameter int AW = 16
) (
  input  logic          rst_n,
  input  logic          clk,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_cs,
  output logic          cpu_ok,
  output logic [7:0]    cpu_dout,
  input  logic          clr,
  output logic [AW-2:0] sdram_addr,
  output logic          sdram_req,
  input  logic          sdram_ack,
  input  logic          sdram_dok,
  input  logic [15:0]   sdram_data,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [15:0]   data_l;
  logic [AW-2:0] tag_l;
  logic          valid;
  logic          hit;
  logic          start;
  logic          fill;
  logic          keep;

  assign hit       = valid && (tag_l == cpu_addr[AW-1:1]);
  assign cpu_ok    = cpu_cs && hit && !clr;
  assign cpu_dout  = cpu_addr[0] ? data_l[15:8] : data_l[7:0];
  assign state_dbg = state;

`ifdef JTFRAME_Z80_ROMCACHE_EN
  assign keep = 1'b1;
`else
  assign keep = cpu_cs;
`endif

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, request level and the start/fill strobes for the datapath.
  always_comb begin
    state_nxt = state;
    sdram_req = 1'b0;
    start     = 1'b0;
    fill      = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_cs && !hit && !clr) begin
          start     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        sdram_req = 1'b1;
        if (sdram_ack) begin
          if (sdram_dok) begin
            fill      = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (sdram_dok) begin
          fill      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Word address latch, held word fill, and the valid flag (clear wins over fill).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdram_addr <= '0;
      data_l     <= '0;
      tag_l      <= '0;
      valid      <= 1'b0;
    end else begin
      if (start) sdram_addr <= cpu_addr[AW-1:1];
      if (fill) begin
        data_l <= sdram_data;
        tag_l  <= sdram_addr;
      end
      if (clr || !keep) valid <= 1'b0;
      else if (fill)    valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtframe_z80_romfetch.sv
// Bench for jtframe_z80_romfetch: directed scenarios followed by random
// CPU accesses, checked against a held-word model (valid/tag/data) and a
// queue of expected SDRAM word addresses. ROM content is a fixed function
// of the word address, with word 0 holding 16'hBEEF.
module tb_jtframe_z80_romfetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic        cpu_cs;
  logic        cpu_ok;
  logic [7:0]  cpu_dout;
  logic        clr;
  logic [14:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack;
  logic        sdram_dok;
  logic [15:0] sdram_data;
  logic [1:0]  state_dbg;

  int n_checks  = 0;
  int n_errs    = 0;
  int req_seen  = 0;
  int exp_reqs  = 0;
  int cyc       = 0;

  logic [14:0] exp_q[$];

  // held-word model
  logic        m_valid;
  logic [14:0] m_tag;
  logic [15:0] m_data;

  jtframe_z80_romfetch #(.AW(16)) dut (
    .rst_n      (rst_n),
    .clk        (clk),
    .cpu_addr   (cpu_addr),
    .cpu_cs     (cpu_cs),
    .cpu_ok     (cpu_ok),
    .cpu_dout   (cpu_dout),
    .clr        (clr),
    .sdram_addr (sdram_addr),
    .sdram_req  (sdram_req),
    .sdram_ack  (sdram_ack),
    .sdram_dok  (sdram_dok),
    .sdram_data (sdram_data),
    .state_dbg  (state_dbg)
  );

  // clock / cycle counter / request counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge sdram_req) req_seen++;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] rom_word(input logic [14:0] w);
    logic [15:0] v;
    v = (16'(w) * 16'h9E37) ^ 16'h5A5A;
    return (w == 15'd0) ? 16'hBEEF : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_out(input string tag);
    logic       eok;
    logic [7:0] ed;
    eok = cpu_cs && m_valid && (m_tag == cpu_addr[15:1]) && !clr;
    ed  = cpu_addr[0] ? m_data[15:8] : m_data[7:0];
    chk({tag, "_ok"}, 32'(cpu_ok), 32'(eok));
    chk({tag, "_dout"}, 32'(cpu_dout), 32'(ed));
  endtask

  task automatic cs_gap();
    cpu_cs = 1'b0;
    tick();
`ifndef JTFRAME_Z80_ROMCACHE_EN
    m_valid = 1'b0;
`endif
  endtask

  task automatic do_clr();
    clr = 1'b1;
    #2 chk_out("clr_cycle");
    tick();
    clr = 1'b0;
    m_valid = 1'b0;
  endtask

  // SDRAM side of one transaction. Entered after the edge that should have
  // raised sdram_req; acks ack_dly cycles after that, then answers dok_dly
  // cycles after the ack (0 = same cycle as the ack).
  task automatic serve(input int ack_dly, input int dok_dly, input bit clr_dok,
                       input bit chg, input logic [15:0] chg_addr, input bit stray);
    logic [14:0] w;
    int n;
    n = 0;
    while (sdram_req !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk("req_seen", 32'(sdram_req), 32'd1);
    if (exp_q.size() == 0) begin
      chk("exp_q_nonempty", 32'd0, 32'd1);
      return;
    end
    w = exp_q.pop_front();
    if (sdram_req !== 1'b1) return;
    chk("req_addr", 32'(sdram_addr), 32'(w));
    for (int i = 1; i < ack_dly; i++) begin
      sdram_dok  = stray && ($urandom_range(0, 1) == 1);
      sdram_data = 16'($urandom);
      tick();
      #2 chk("req_hold", 32'({sdram_req, sdram_addr}), 32'({1'b1, w}));
    end
    sdram_dok = 1'b0;
    sdram_ack = 1'b1;
    if (dok_dly == 0) begin
      sdram_dok  = 1'b1;
      sdram_data = rom_word(w);
      clr        = clr_dok;
    end
    tick();
    sdram_ack = 1'b0;
    if (dok_dly != 0) begin
      if (chg) cpu_addr = chg_addr;
      #2 chk("req_drop", 32'(sdram_req), 32'd0);
      chk_out("wait");
      for (int i = 1; i < dok_dly; i++) begin
        tick();
        #2 chk("req_low_wait", 32'(sdram_req), 32'd0);
      end
      sdram_dok  = 1'b1;
      sdram_data = rom_word(w);
      clr        = clr_dok;
      #2 chk_out("dok_cycle");
      tick();
    end
    sdram_dok  = 1'b0;
    clr        = 1'b0;
    sdram_data = 16'($urandom);
    m_data  = rom_word(w);
    m_tag   = w;
`ifdef JTFRAME_Z80_ROMCACHE_EN
    m_valid = !clr_dok;
`else
    m_valid = !clr_dok && cpu_cs;
`endif
    #2 chk_out("fill");
  endtask

  initial begin
    logic [15:0] a;
    int t0;
    // reset
    rst_n = 1'b0; cpu_cs = 1'b0; cpu_addr = 16'h0000; clr = 1'b0;
    sdram_ack = 1'b0; sdram_dok = 1'b0; sdram_data = 16'h0000;
    m_valid = 1'b0; m_tag = '0; m_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req", 32'(sdram_req), 32'd0);
    chk("reset_addr", 32'(sdram_addr), 32'd0);
    chk_out("reset");
    rst_n = 1'b1;
    repeat (3) tick();
    chk("no_req_without_cs", 32'(req_seen), 32'd0);

    // first miss on word 0: ack 2 clocks after req, dok 3 clocks after ack
    cpu_addr = 16'h0000; cpu_cs = 1'b1;
    #2 chk_out("t1_pre");
    exp_q.push_back(15'h0000); exp_reqs++;
    tick();
    serve(2, 3, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("t1_ok", 32'(cpu_ok), 32'd1);
    chk("t1_dout", 32'(cpu_dout), 32'hEF);
    chk("t1_reqs", 32'(req_seen), 32'd1);

    // odd byte of the same word, cs held: immediate hit
    cpu_addr = 16'h0001;
    #1 chk("t2_ok", 32'(cpu_ok), 32'd1);
    chk("t2_dout", 32'(cpu_dout), 32'hBE);
    repeat (3) tick();
    chk("t2_reqs", 32'(req_seen), 32'd1);

    // cs gap then word 0 again
    cs_gap();
    cpu_addr = 16'h0000; cpu_cs = 1'b1;
    #1;
`ifdef JTFRAME_Z80_ROMCACHE_EN
    chk("t3_ok", 32'(cpu_ok), 32'd1);
    chk("t3_dout", 32'(cpu_dout), 32'hEF);
    tick();
    chk("t3_reqs", 32'(req_seen), 32'd1);
`else
    chk("t3_ok", 32'(cpu_ok), 32'd0);
    exp_q.push_back(15'h0000); exp_reqs++;
    tick();
    serve(1, 1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("t3_reqs", 32'(req_seen), 32'(exp_reqs));
`endif

    // address change during WAIT: word 0 still fills, then word 0x091A
    do_clr();
    exp_q.push_back(15'h0000); exp_reqs++;
    tick();
    serve(1, 2, 1'b0, 1'b1, 16'h1234, 1'b0);
    cpu_addr = 16'h0000;
    #1 chk("t4_tag0_ok", 32'(cpu_ok), 32'd1);
    chk("t4_tag0_dout", 32'(cpu_dout), 32'hEF);
    cpu_addr = 16'h1234;
    exp_q.push_back(15'h091A); exp_reqs++;
    tick();
    chk("t4_addr", 32'(sdram_addr), 32'h091A);
    serve(1, 1, 1'b0, 1'b0, 16'h0, 1'b0);

    // clr on the dok edge: no valid, request follows
    cpu_addr = 16'h0002;
    exp_q.push_back(15'h0001); exp_reqs++;
    tick();
    serve(1, 2, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("t5_ok_after_clr", 32'(cpu_ok), 32'd0);
    exp_q.push_back(15'h0001); exp_reqs++;
    tick();
    serve(2, 1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("t5_reqs", 32'(req_seen), 32'(exp_reqs));

    // ack and dok in the same cycle
    cpu_addr = 16'h0005;
    exp_q.push_back(15'h0002); exp_reqs++;
    tick();
    serve(1, 0, 1'b0, 1'b0, 16'h0, 1'b0);

    // back-to-back latency: three clocks from access to ok
    cpu_addr = 16'h0007;
    t0 = cyc;
    exp_q.push_back(15'h0003); exp_reqs++;
    tick();
    serve(1, 1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("latency", 32'(cyc - t0), 32'd3);

    // stray dok in IDLE is ignored
    sdram_dok = 1'b1; sdram_data = 16'h1111;
    #2 chk_out("stray_idle_pre");
    tick();
    sdram_dok = 1'b0;
    #2 chk_out("stray_idle");
    chk("stray_idle_reqs", 32'(req_seen), 32'(exp_reqs));

    // random accesses over a few words
    for (int it = 0; it < 60; it++) begin
      a = 16'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) a[15] = 1'b1;
      cpu_addr = a; cpu_cs = 1'b1;
      #2 chk_out("rnd_pre");
      if (m_valid && m_tag == a[15:1]) begin
        tick();
        #2 chk_out("rnd_hit");
      end else begin
        exp_q.push_back(a[15:1]); exp_reqs++;
        tick();
        serve($urandom_range(1, 3), $urandom_range(0, 3), $urandom_range(0, 4) == 0,
              1'b0, 16'h0, 1'b1);
      end
      chk("rnd_reqs", 32'(req_seen), 32'(exp_reqs));
      if ($urandom_range(0, 2) == 0) cs_gap();
    end

    // reset during REQ, then stray handshakes
    cpu_addr = 16'h0100; cpu_cs = 1'b1;
    if (m_valid && m_tag == 15'h0080) do_clr();
    m_valid = 1'b0;
    tick();
    exp_reqs++;
    chk("t7_req_up", 32'(sdram_req), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("t7_req_async_drop", 32'(sdram_req), 32'd0);
    m_valid = 1'b0; m_tag = '0; m_data = '0;
    chk_out("t7_in_reset");
    cpu_cs = 1'b0;
    tick();
    sdram_ack = 1'b1; sdram_dok = 1'b1; sdram_data = 16'h5A5A;
    tick();
    sdram_ack = 1'b0; sdram_dok = 1'b0;
    rst_n = 1'b1;
    tick();
    sdram_dok = 1'b1; sdram_data = 16'hA5A5;
    tick();
    sdram_dok = 1'b0;
    #2 chk_out("t7_after_stray");
    chk("t7_reqs", 32'(req_seen), 32'(exp_reqs));
    cpu_cs = 1'b1;
    #1 chk_out("t7_cs_pre");
    exp_q.push_back(15'h0080); exp_reqs++;
    tick();
    serve(1, 1, 1'b0, 1'b0, 16'h0, 1'b0);

    chk("final_reqs", 32'(req_seen), 32'(exp_reqs));
    chk("final_queue", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
